// File: rtl/cells_frame_sequencer.sv
// Frame sequencer feeding cells_controller: FIFO-buffered host frames,
// each held on cells_state for a programmable number of controller scans.
module cells_frame_sequencer #(
   parameter int DEPTH    = 8,
   parameter int FRAME_W  = 16,
   parameter int REPEAT_W = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_valid,
   input  logic [FRAME_W-1:0]       wr_data,
   output logic                     wr_ready,
   input  logic [REPEAT_W-1:0]      repeat_count,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     update_done,
   output logic [FRAME_W-1:0]       cells_state,
   output logic                     system_enable_n,
   output logic                     enable_sn,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     underrun
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t              state_q, state_d;
   logic [FRAME_W-1:0]  mem_q [DEPTH];
   logic [AW:0]         wptr_q, rptr_q, level;
   logic [FRAME_W-1:0]  cells_q;
   logic [REPEAT_W-1:0] cnt_q;
   logic                ud_q, stop_pend_q, first_q, underrun_q;
   logic                push, pop, scan_done, stop_now, expire;

   assign level     = wptr_q - rptr_q;
   assign wr_ready  = (level != (AW+1)'(DEPTH));
   assign push      = wr_valid & wr_ready;
   assign pop       = (state_q == LOAD);
   assign scan_done = update_done & ~ud_q;
   assign stop_now  = stop_pend_q | stop;
   assign expire    = (state_q == RUN) & scan_done & (cnt_q == REPEAT_W'(1));

   assign cells_state = cells_q;
   assign fifo_level  = level;
   assign underrun    = underrun_q;

   // Storage needs no reset; pointers alone define validity.
   always_ff @(posedge clock) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= wr_data;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start && level != '0) state_d = LOAD;
         LOAD: state_d = RUN;
         RUN: begin
            if (expire) begin
               if (stop_now)           state_d = IDLE;
               else if (level != '0)   state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy            = (state_q != IDLE);
      system_enable_n = (state_q == IDLE);
      enable_sn       = (state_q == LOAD) & first_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ud_q        <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         cells_q     <= '0;
         cnt_q       <= '0;
         stop_pend_q <= 1'b0;
         first_q     <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ud_q    <= update_done;
         wptr_q  <= wptr_q + (AW+1)'(push);
         if (pop) begin
            rptr_q  <= rptr_q + (AW+1)'(1);
            cells_q <= mem_q[rptr_q[AW-1:0]];
            cnt_q   <= (repeat_count == '0) ? REPEAT_W'(1) : repeat_count;
         end else if (state_q == RUN && scan_done && cnt_q > REPEAT_W'(1)) begin
            cnt_q <= cnt_q - REPEAT_W'(1);
         end
         if (state_d == IDLE)
            stop_pend_q <= 1'b0;
         else if (stop && state_q != IDLE)
            stop_pend_q <= 1'b1;
         if (state_q == IDLE && state_d == LOAD)
            first_q <= 1'b1;
         else if (state_q == LOAD)
            first_q <= 1'b0;
         // An expiry with nothing queued keeps the old frame and flags it.
         if (state_q == IDLE && start)
            underrun_q <= 1'b0;
         else if (expire && !stop_now && level == '0)
            underrun_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cells_frame_sequencer.sv
// Bench for cells_frame_sequencer: directed sequences, a repeat-count
// table, and randomized traffic against a queue-based reference model.
module tb_cells_frame_sequencer;

   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wr_valid = 1'b0;
   logic [15:0] wr_data = '0;
   logic        wr_ready;
   logic [7:0]  repeat_count = 8'd1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        update_done = 1'b0;
   logic [15:0] cells_state;
   logic        system_enable_n;
   logic        enable_sn;
   logic        busy;
   logic [3:0]  fifo_level;
   logic        underrun;

   int checks = 0;
   int errors = 0;

   cells_frame_sequencer #(.DEPTH(DEPTH), .FRAME_W(16), .REPEAT_W(8)) dut (
      .clock(clock), .reset(reset),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .repeat_count(repeat_count), .start(start), .stop(stop),
      .update_done(update_done), .cells_state(cells_state),
      .system_enable_n(system_enable_n), .enable_sn(enable_sn),
      .busy(busy), .fifo_level(fifo_level), .underrun(underrun)
   );

   always #5 clock = ~clock;

   // Reference model: frames in a queue, a mode (0 idle, 1 load, 2 run),
   // scans remaining for the shown frame.
   logic [15:0] mq[$];
   logic [15:0] m_cur;
   int          m_left, m_mode, lvl;
   bit          m_first, m_stp, m_und, m_ud, scn, psh;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_cur = '0; m_left = 0; m_mode = 0;
         m_first = 0; m_stp = 0; m_und = 0; m_ud = 0;
      end else begin
         lvl = mq.size();
         psh = wr_valid && (lvl < DEPTH);
         scn = update_done && !m_ud;
         m_ud = update_done;
         case (m_mode)
            0: if (start) begin
               m_und = 0;
               if (lvl > 0) begin m_mode = 1; m_first = 1; end
            end
            1: begin
               m_cur = mq.pop_front();
               m_left = (repeat_count == 0) ? 1 : int'(repeat_count);
               m_mode = 2; m_first = 0;
               if (stop) m_stp = 1;
            end
            default: begin
               if (stop) m_stp = 1;
               if (scn) begin
                  if (m_left > 1) m_left--;
                  else if (m_stp) begin m_mode = 0; m_stp = 0; end
                  else if (lvl > 0) m_mode = 1;
                  else m_und = 1;
               end
            end
         endcase
         if (psh) mq.push_back(wr_data);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_valid = 0; start = 0; stop = 0; update_done = 0; repeat_count = 8'd1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic wr(input logic [15:0] d);
      wr_valid = 1'b1; wr_data = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic go();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic scan_chk(input string name, input logic [15:0] exp);
      update_done = 1'b1; tick(); tick();
      chk(name, cells_state, exp);
      update_done = 1'b0; tick();
   endtask

   task automatic cmp_model();
      chk("rnd_cells", cells_state, m_cur);
      chk("rnd_busy", busy, m_mode != 0);
      chk("rnd_sen", system_enable_n, m_mode == 0);
      chk("rnd_esn", enable_sn, m_mode == 1 && m_first);
      chk("rnd_level", fifo_level, mq.size());
      chk("rnd_wr_ready", wr_ready, mq.size() < DEPTH);
      chk("rnd_underrun", underrun, m_und);
   endtask

   typedef struct {
      logic [7:0]  rc;
      logic [15:0] frame;
      int          scans;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int n, ud_left;
      tbl[0] = '{8'd0, 16'h0A0A, 1};
      tbl[1] = '{8'd1, 16'h0B0B, 1};
      tbl[2] = '{8'd2, 16'h0C0C, 2};
      tbl[3] = '{8'd5, 16'h0D0D, 5};
      tbl[4] = '{8'd3, 16'h0E0E, 3};

      // Reset values
      do_reset();
      chk("rst_cells", cells_state, 0);
      chk("rst_sen", system_enable_n, 1);
      chk("rst_esn", enable_sn, 0);
      chk("rst_busy", busy, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_wr_ready", wr_ready, 1);

      // Two frames, one scan each, enable_sn only on first load
      wr(16'h0155); wr(16'h02AA);
      repeat_count = 8'd1;
      go();
      chk("t1_esn_first", enable_sn, 1);
      tick();
      chk("t1_frame0", cells_state, 16'h0155);
      chk("t1_esn_low", enable_sn, 0);
      chk("t1_sen", system_enable_n, 0);
      update_done = 1'b1; tick();
      chk("t1_esn_second_load", enable_sn, 0);
      tick();
      chk("t1_frame1", cells_state, 16'h02AA);
      update_done = 1'b0; tick();

      // Repeat 3 with long update_done levels, then underrun
      do_reset();
      wr(16'h03FF);
      repeat_count = 8'd3;
      go(); tick();
      chk("t2_frame", cells_state, 16'h03FF);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) chk("t2_no_underrun_yet", underrun, 0);
         update_done = 1'b1; repeat (40) tick();
         update_done = 1'b0; repeat (5) tick();
      end
      chk("t2_underrun", underrun, 1);
      chk("t2_frame_kept", cells_state, 16'h03FF);
      chk("t2_busy", busy, 1);

      // Full FIFO, dropped write, write during a pop
      do_reset();
      for (int i = 0; i < 9; i++) begin
         if (i == 8) chk("t3_wr_ready_full", wr_ready, 0);
         wr(16'h0010 + 16'(i));
      end
      chk("t3_level_full", fifo_level, 8);
      repeat_count = 8'd1;
      go(); tick();
      chk("t3_first", cells_state, 16'h0010);
      chk("t3_level_after_pop", fifo_level, 7);
      update_done = 1'b1; tick();
      wr_valid = 1'b1; wr_data = 16'hABCD; tick(); wr_valid = 1'b0;
      chk("t3_level_wr_pop", fifo_level, 7);
      chk("t3_second", cells_state, 16'h0011);
      update_done = 1'b0; tick();
      for (int i = 2; i < 8; i++) scan_chk("t3_seq", 16'h0010 + 16'(i));
      scan_chk("t3_written_frame", 16'hABCD);

      // Stop mid-scan with two frames queued
      do_reset();
      wr(16'h00A1); wr(16'h00B2); wr(16'h00C3);
      repeat_count = 8'd1;
      go(); tick();
      chk("t4_level", fifo_level, 2);
      stop = 1'b1; tick(); stop = 1'b0;
      chk("t4_busy_after_stop", busy, 1);
      update_done = 1'b1; tick();
      chk("t4_idle", busy, 0);
      chk("t4_sen", system_enable_n, 1);
      chk("t4_level_kept", fifo_level, 2);
      chk("t4_frame_kept", cells_state, 16'h00A1);
      update_done = 1'b0; tick();

      // Start with empty FIFO stays idle
      do_reset();
      go(); tick();
      chk("t5_busy", busy, 0);
      chk("t5_underrun", underrun, 0);
      chk("t5_sen", system_enable_n, 1);

      // Asynchronous reset while running
      wr(16'h1111); wr(16'h2222);
      go(); tick();
      chk("t6_running", busy, 1);
      reset = 1'b1; #2;
      chk("t6_cells", cells_state, 0);
      chk("t6_busy", busy, 0);
      chk("t6_level", fifo_level, 0);
      chk("t6_sen", system_enable_n, 1);
      chk("t6_esn", enable_sn, 0);
      chk("t6_underrun", underrun, 0);
      tick();
      reset = 1'b0;

      // Repeat-count table: scans held before the next frame appears
      foreach (tbl[k]) begin
         do_reset();
         wr(tbl[k].frame); wr(16'h1234);
         repeat_count = tbl[k].rc;
         go(); tick();
         chk("tbl_frame", cells_state, tbl[k].frame);
         n = 0;
         while (cells_state == tbl[k].frame && n < 12) begin
            update_done = 1'b1; tick(); tick();
            update_done = 1'b0; tick();
            n++;
         end
         chk("tbl_scans", n, tbl[k].scans);
         chk("tbl_next", cells_state, 16'h1234);
      end

      // Randomized traffic against the model
      do_reset();
      ud_left = 3;
      for (int c = 0; c < 3000; c++) begin
         wr_valid     = ($urandom_range(0, 99) < 40);
         wr_data      = 16'($urandom);
         start        = ($urandom_range(0, 99) < 5);
         stop         = ($urandom_range(0, 99) < 2);
         repeat_count = 8'($urandom_range(0, 3));
         if (ud_left == 0) begin
            update_done = ~update_done;
            ud_left = $urandom_range(1, 5);
         end else begin
            ud_left--;
         end
         tick();
         cmp_model();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
